// File: rtl/g15_track_pkg.sv
// Shared types and constants for the G-15 style serial command track.
package g15_track_pkg;

    localparam int unsigned G15_WORD_BITS = 29;

    typedef enum logic [1:0] {TM_RECIRC, TM_ADD, TM_LOAD, TM_CLEAR} track_mode_t;

    // Controls held constant for one word, captured at bit 0.
    typedef struct packed {
        track_mode_t mode;
        logic        alt;
        logic        cin;
    } word_ctl_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/track_shift_reg.sv
// Serial shift register forming the recirculating track storage.
module track_shift_reg #(
    parameter int unsigned N = 29
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_dout
);

    logic [N-1:0] r_sr;

    generate
        if (N == 1) begin : g_single
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= i_din;
                end
            end
        end else begin : g_chain
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[N-2:0], i_din};
                end
            end
        end
    endgenerate

    assign o_dout = r_sr[N-1];

endmodule

// File: rtl/cmd_track_adder.sv
// Bit-serial command track with a windowed serial adder, overflow capture and
// load/recirculate/clear modes.
module cmd_track_adder
    import g15_track_pkg::*;
#(
    parameter int unsigned WORD_BITS  = G15_WORD_BITS,
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned LO_BIT     = 2,
    parameter int unsigned HI_BIT     = 28,
    parameter int unsigned ALT_HI_BIT = 21
) (
    input  logic                         CLOCK,
    input  logic                         rst,
    input  logic                         WORD_SYNC,
    input  logic [1:0]                   mode,
    input  logic                         alt_window,
    input  logic                         addend_in,
    input  logic                         load_in,
    input  logic                         carry_in_en,
    input  logic                         block_top,
    output logic                         dout,
    output logic                         sum_out,
    output logic [$clog2(WORD_BITS)-1:0] bit_time,
    output logic                         in_window,
    output logic                         word_done,
    output logic                         carry_out
);

    localparam int unsigned BW = $clog2(WORD_BITS);
    localparam int unsigned TRACK_LEN = WORD_BITS * DEPTH;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);
    localparam logic [BW-1:0] LO_IDX = BW'(LO_BIT);
    localparam logic [BW-1:0] HI_IDX = BW'(HI_BIT);
    localparam logic [BW-1:0] ALT_HI_IDX = BW'(ALT_HI_BIT);

    generate
        if (!((LO_BIT < ALT_HI_BIT) && (ALT_HI_BIT <= HI_BIT) && (HI_BIT < WORD_BITS) &&
              (DEPTH >= 1))) begin : g_bad_params
            $fatal(1, "cmd_track_adder: illegal window/depth parameters");
        end
    endgenerate

    logic [BW-1:0] r_bit_cnt;
    logic [BW-1:0] w_bit_time;
    logic [BW-1:0] w_bit_next;
    word_ctl_t     r_ctl;
    word_ctl_t     w_ctl;
    logic          r_carry;
    logic          r_carry_out;
    logic          w_first;
    logic          w_last;
    logic [BW-1:0] w_top;
    logic          w_win;
    logic          w_adding;
    logic          w_carry_prev;
    logic          w_carry_in;
    logic          w_carry_next;
    logic          w_sum_add;
    logic          w_sum;
    logic          w_dout;

    always_comb begin
        w_bit_time = WORD_SYNC ? '0 : r_bit_cnt;
        w_first    = (w_bit_time == '0);
        w_last     = (w_bit_time == LAST_BIT);
        w_bit_next = w_last ? '0 : w_bit_time + BW'(1);

        // Bit 0 acts on the live controls so the whole word uses one setting.
        w_ctl = r_ctl;
        if (w_first) begin
            w_ctl.mode = track_mode_t'(mode);
            w_ctl.alt  = alt_window;
            w_ctl.cin  = carry_in_en;
        end

        w_top = w_ctl.alt ? ALT_HI_IDX : HI_IDX;
        w_win = (w_bit_time >= LO_IDX) && (w_bit_time <= w_top);
    end

    always_comb begin
        w_adding     = (w_ctl.mode == TM_ADD) && w_win;
        w_carry_prev = w_first ? 1'b0 : r_carry;
        w_carry_in   = (w_bit_time == LO_IDX) ? w_ctl.cin : w_carry_prev;
        w_sum_add    = w_dout ^ addend_in ^ w_carry_in;
        // Past the window top the carry is held so it can be reported at word end.
        w_carry_next = w_adding ? maj3(w_dout, addend_in, w_carry_in) : w_carry_prev;

        w_sum = w_dout;
        unique case (w_ctl.mode)
            TM_RECIRC: w_sum = w_dout;
            TM_ADD:    w_sum = w_adding ? w_sum_add : w_dout;
            TM_LOAD:   w_sum = load_in;
            TM_CLEAR:  w_sum = 1'b0;
        endcase
        if (w_last && block_top) begin
            w_sum = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_ctl       <= '{mode: TM_RECIRC, alt: 1'b0, cin: 1'b0};
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
        end else begin
            r_bit_cnt <= w_bit_next;
            r_ctl     <= w_ctl;
            r_carry   <= w_carry_next;
            if (w_last) begin
                r_carry_out <= (w_ctl.mode == TM_ADD) && w_carry_next;
            end
        end
    end

    track_shift_reg #(
        .N(TRACK_LEN)
    ) u_track (
        .i_clk (CLOCK),
        .i_rst (rst),
        .i_din (w_sum),
        .o_dout(w_dout)
    );

    assign dout      = w_dout;
    assign sum_out   = w_sum;
    assign bit_time  = w_bit_time;
    assign in_window = w_win;
    assign word_done = w_last;
    assign carry_out = r_carry_out;

endmodule
